stream_fifo: RTL and testbench

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/stream_fifo.sv | 74 +++++++
 tb/tb_stream_fifo.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// Synchronous single-clock stream FIFO with valid/ready handshakes on both sides.
// Status outputs are decoded from registered pointers/count only, so the ports carry no input-to-output paths.
module stream_fifo #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int ALMOST_FULL = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       input_valid,
    input  logic [WIDTH-1:0]           input_data,
    output logic                       input_ready,
    output logic                       output_valid,
    output logic [WIDTH-1:0]           output_data,
    input  logic                       output_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             insert, remove, write_en;

    assign input_ready  = (count_q != CNT_W'(DEPTH));
    assign output_valid = (count_q != '0);
    assign output_data  = mem_q[rd_ptr_q];
    assign count        = count_q;
    assign almost_full  = (count_q >= CNT_W'(ALMOST_FULL));

    assign insert = input_valid && input_ready;
    assign remove = output_valid && output_ready;

    // Reset outranks flush, flush outranks any transfer; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        write_en = 1'b0;
        if (reset || flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (insert) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                write_en = 1'b1;
            end
            if (remove) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(insert) - CNT_W'(remove);
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[wr_ptr_q] <= input_data;
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo: a queue-based reference model tracks accepted words,
// and a negedge monitor compares every DUT output against it.
module tb_stream_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             reset, flush, input_valid, output_ready;
    logic [WIDTH-1:0] input_data;
    logic             input_ready, output_valid, almost_full;
    logic [WIDTH-1:0] output_data;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    logic [WIDTH-1:0] exp_q [$];
    int               sz;
    bit               m_ins, m_rem;
    logic [WIDTH-1:0] held;

    stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALMOST_FULL(AF)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .input_valid  (input_valid),
        .input_data   (input_data),
        .input_ready  (input_ready),
        .output_valid (output_valid),
        .output_data  (output_data),
        .output_ready (output_ready),
        .count        (count),
        .almost_full  (almost_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO queue with occupancy limit DEPTH; handshakes judged from pre-edge occupancy.
    always @(posedge clk) begin
        sz = exp_q.size();
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            m_ins = input_valid && (sz != DEPTH);
            m_rem = output_ready && (sz != 0);
            if (m_rem) void'(exp_q.pop_front());
            if (m_ins) exp_q.push_back(input_data);
        end
    end

    // Monitor: every cycle compare status against model occupancy, and data against the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            check("count", count, exp_q.size());
            check("input_ready", input_ready, exp_q.size() != DEPTH);
            check("output_valid", output_valid, exp_q.size() != 0);
            check("almost_full", almost_full, exp_q.size() >= AF);
            if (exp_q.size() != 0) check("output_data", output_data, exp_q[0]);
        end
    end

    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
        input_valid  = v;
        input_data   = d;
        output_ready = r;
        flush        = f;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; input_valid = 1'b0; output_ready = 1'b0; input_data = '0;
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 32'h1234, 1'b1, 1'b1);
        reset = 1'b0;
        mon_en = 1'b1;
        check("rst_count", count, 0);
        check("rst_in_ready", input_ready, 1);
        check("rst_out_valid", output_valid, 0);
        check("rst_almost_full", almost_full, 0);

        // Fill to full with the output stalled, then drain in order.
        cyc(1'b1, 32'hA1, 1'b0, 1'b0);
        cyc(1'b1, 32'hA2, 1'b0, 1'b0);
        check("af_at_2", almost_full, 0);
        cyc(1'b1, 32'hA3, 1'b0, 1'b0);
        check("af_at_3", almost_full, 1);
        cyc(1'b1, 32'hA4, 1'b0, 1'b0);
        check("full_count", count, 4);
        check("full_in_ready", input_ready, 0);
        check("full_head", output_data, 32'hA1);
        cyc(1'b1, 32'hDEAD, 1'b0, 1'b0);
        check("full_ignore_count", count, 4);
        for (int i = 0; i < 4; i++) begin
            check("drain_order", output_data, 32'hA1 + i);
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        check("drained_count", count, 0);

        // One-cycle latency through an empty FIFO.
        cyc(1'b1, 32'h55, 1'b1, 1'b0);
        check("lat_valid", output_valid, 1);
        check("lat_data", output_data, 32'h55);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("lat_gone", output_valid, 0);

        // Full FIFO with simultaneous push/pop streaming.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
        check("stream_ready_lo", input_ready, 0);
        cyc(1'b1, $urandom, 1'b1, 1'b0);
        check("stream_ready_hi", input_ready, 1);
        check("stream_count", count, DEPTH - 1);
        for (int i = 0; i < 20; i++) cyc(1'b1, $urandom, 1'b1, 1'b0);
        drain();

        // Stall hold with two entries.
        cyc(1'b1, 32'hB1, 1'b0, 1'b0);
        cyc(1'b1, 32'hB2, 1'b0, 1'b0);
        held = output_data;
        check("hold_head", held, 32'hB1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            check("hold_valid", output_valid, 1);
            check("hold_data", output_data, held);
        end
        drain();

        // Flush with a concurrent insert.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hC0 + i, 1'b0, 1'b0);
        cyc(1'b1, 32'hBAD, 1'b1, 1'b1);
        check("flush_count", count, 0);
        check("flush_valid", output_valid, 0);
        check("flush_ready", input_ready, 1);
        cyc(1'b1, 32'h77, 1'b0, 1'b0);
        check("post_flush_data", output_data, 32'h77);
        drain();

        // Random stress with a reset pulse midway.
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) reset = 1'b1;
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                $urandom_range(0, 499) == 0);
            if (i == 5000) begin
                reset = 1'b0;
                check("midrun_reset_count", count, 0);
            end
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
